// File: rtl/reg_writeback_queue_if.sv
// Producer/register-file/decode-side signal bundle for reg_writeback_queue.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface reg_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data;
    logic              wr_hold;
    logic [ADDR_W-1:0] wr_dest;
    logic [DATA_W-1:0] wr_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] chk_one;
    logic [ADDR_W-1:0] chk_two;
    logic              busy_one;
    logic              busy_two;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_dest, in_data, wr_hold, chk_one, chk_two,
        output in_ready, wr_dest, wr_data, wr_enable, busy_one, busy_two, count
    );

    modport master (
        output in_valid, in_dest, in_data, wr_hold, chk_one, chk_two,
        input  in_ready, wr_dest, wr_data, wr_enable, busy_one, busy_two, count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Write-back FIFO feeding the register-file write port, one write per cycle,
// with a pending-write scoreboard lookup for decode stalls.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    reg_writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    logic              wr_enable_q;
    logic [ADDR_W-1:0] wr_dest_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DEPTH-1:0]  occupied;

    // No bypass: a full queue refuses input even when it drains this cycle.
    assign bus.in_ready = (count_q != CNT_W'(DEPTH));
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count_q != '0) && !bus.wr_hold;

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = (CNT_W'(PTR_W'(PTR_W'(i) - head)) < count_q);
        end
    end

    function automatic logic busy_for(input logic [ADDR_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (dest_mem[i] == idx)) hit = 1'b1;
        end
        return (idx != '0) && (hit || (wr_enable_q && (wr_dest_q == idx)));
    endfunction

    assign bus.busy_one = busy_for(bus.chk_one);
    assign bus.busy_two = busy_for(bus.chk_two);

    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[tail] <= bus.in_dest;
            data_mem[tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            wr_enable_q <= 1'b0;
            wr_dest_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head        <= head + 1'b1;
                wr_dest_q   <= dest_mem[head];
                wr_data_q   <= data_mem[head];
                // x0 entries drain without touching the register file.
                wr_enable_q <= (dest_mem[head] != '0);
            end else begin
                wr_enable_q <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_dest   = wr_dest_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_reg_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;

    reg_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of pending writes plus the last write presented.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_dest;
    logic [DATA_W-1:0] m_data;

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_dest = '0;
        m_data = '0;
    endtask

    function automatic logic m_busy(input logic [ADDR_W-1:0] c);
        if (c == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].dest == c) return 1'b1;
        return m_we && (m_dest == c);
    endfunction

    task automatic model_edge(input logic v, input logic [ADDR_W-1:0] d,
                              input logic [DATA_W-1:0] dat, input logic h);
        logic accept;
        ent_t e;
        accept = v && (mq.size() < DEPTH);
        if (mq.size() > 0 && !h) begin
            e      = mq.pop_front();
            m_we   = (e.dest != 0);
            m_dest = e.dest;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (accept) mq.push_back('{dest: d, data: dat});
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"},  64'(bus_if.count),    64'(mq.size()));
        check({tag, "_ready"},  64'(bus_if.in_ready), 64'(mq.size() < DEPTH));
        check({tag, "_busy1"},  64'(bus_if.busy_one), 64'(m_busy(bus_if.chk_one)));
        check({tag, "_busy2"},  64'(bus_if.busy_two), 64'(m_busy(bus_if.chk_two)));
        check({tag, "_we"},     64'(bus_if.wr_enable), 64'(m_we));
        check({tag, "_wdest"},  64'(bus_if.wr_dest),  64'(m_dest));
        check({tag, "_wdata"},  64'(bus_if.wr_data),  64'(m_data));
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] dat,
                        input logic h, input logic [ADDR_W-1:0] c1, input logic [ADDR_W-1:0] c2,
                        input string tag);
        bus_if.in_valid = v;
        bus_if.in_dest  = d;
        bus_if.in_data  = dat;
        bus_if.wr_hold  = h;
        bus_if.chk_one  = c1;
        bus_if.chk_two  = c2;
        #1;
        check_model({tag, "_pre"});
        @(posedge clk);
        model_edge(v, d, dat, h);
        @(negedge clk);
        check_model({tag, "_post"});
    endtask

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] dat;
        logic              h;
        logic [ADDR_W-1:0] c1;
        logic [ADDR_W-1:0] c2;
        logic              e_we;
        logic [ADDR_W-1:0] e_dest;
        logic [DATA_W-1:0] e_data;
        logic [2:0]        e_cnt;
        logic              e_rdy;
        logic              e_b1;
        logic              e_b2;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // v  d  data           h  c1 c2 | we dest data          cnt rdy b1 b2  (after the edge)
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        3'd1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd1, 5'd4, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd1, 5'd4, 1'b0, 5'd5, 32'hDEADBEEF, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd1, 5'd4, 1'b0, 5'd5, 32'hDEADBEEF, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd1, 5'd4, 1'b0, 5'd5, 32'hDEADBEEF, 3'd4, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd4, 1'b0, 5'd5, 32'hDEADBEEF, 3'd4, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd9, 5'd4, 1'b1, 5'd1, 32'h11,       3'd3, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd4, 1'b1, 5'd2, 32'h22,       3'd2, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd4, 1'b1, 5'd3, 32'h33,       3'd1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd4, 1'b1, 5'd4, 32'h44,       3'd0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd4, 1'b0, 5'd4, 32'h44,       3'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 32'h44,       3'd1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h1234,     3'd0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 5'd8, 1'b0, 5'd0, 32'h1234,     3'd1, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8, 1'b1, 5'd7, 32'h77,       3'd0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8, 1'b0, 5'd7, 32'h77,       3'd0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_dest  = '0;
        bus_if.in_data  = '0;
        bus_if.wr_hold  = 1'b0;
        bus_if.chk_one  = '0;
        bus_if.chk_two  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", 64'(bus_if.count), 64'd0);
        check("rst_we",    64'(bus_if.wr_enable), 64'd0);
        check("rst_dest",  64'(bus_if.wr_dest), 64'd0);
        check("rst_data",  64'(bus_if.wr_data), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(bus_if.in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].dat, tbl[i].h, tbl[i].c1, tbl[i].c2, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_we", i),   64'(bus_if.wr_enable), 64'(tbl[i].e_we));
            check($sformatf("vec%0d_dest", i), 64'(bus_if.wr_dest),   64'(tbl[i].e_dest));
            check($sformatf("vec%0d_data", i), 64'(bus_if.wr_data),   64'(tbl[i].e_data));
            check($sformatf("vec%0d_cnt", i),  64'(bus_if.count),     64'(tbl[i].e_cnt));
            check($sformatf("vec%0d_rdy", i),  64'(bus_if.in_ready),  64'(tbl[i].e_rdy));
            check($sformatf("vec%0d_b1", i),   64'(bus_if.busy_one),  64'(tbl[i].e_b1));
            check($sformatf("vec%0d_b2", i),   64'(bus_if.busy_two),  64'(tbl[i].e_b2));
        end

        // Back-to-back pushes with no hold: occupancy stays at one, writes emerge in order.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'(i + 1), 32'(i * 16 + 1), 1'b0, 5'd3, 5'd6, $sformatf("stream%0d", i));
            check($sformatf("stream%0d_cnt_le1", i), 64'(bus_if.count <= 1), 64'd1);
            if (i > 0) begin
                check($sformatf("stream%0d_order", i), 64'(bus_if.wr_dest), 64'(i));
                check($sformatf("stream%0d_we", i), 64'(bus_if.wr_enable), 64'd1);
            end
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, "stream_tail");
        check("stream_last_dest", 64'(bus_if.wr_dest), 64'd10);
        check("stream_last_data", 64'(bus_if.wr_data), 64'd145);

        // Reset while a write is on the port and more are queued.
        step(1'b1, 5'd11, 32'hA1, 1'b1, 5'd11, 5'd12, "rsth0");
        step(1'b1, 5'd12, 32'hA2, 1'b1, 5'd11, 5'd12, "rsth1");
        step(1'b1, 5'd13, 32'hA3, 1'b1, 5'd11, 5'd12, "rsth2");
        step(1'b0, 5'd0,  32'h0,  1'b0, 5'd11, 5'd12, "rsth3");
        check("rst_mid_pending_we", 64'(bus_if.wr_enable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_count", 64'(bus_if.count), 64'd0);
        check("rst_mid_we",    64'(bus_if.wr_enable), 64'd0);
        check("rst_mid_busy",  64'(bus_if.busy_two), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd12, 5'd13, $sformatf("after_rst%0d", i));
            check($sformatf("after_rst%0d_no_write", i), 64'(bus_if.wr_enable), 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Producer side of the register-file write port. Buffers retiring results (destination index plus 32-bit value) in a small FIFO.
- Drives the register file's dest / write_enable / data_in inputs, one write per cycle.
- Exposes a pending-write check so decode can stall when a source register still has a write queued or in flight.
- Sits between the execute/load units and the register file.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a result
in_ready  output  1  queue can accept this cycle
in_dest  input  ADDR_W  destination register index
in_data  input  DATA_W  result value
wr_hold  input  1  inhibit draining (write port borrowed elsewhere)
wr_dest  output  ADDR_W  to register file dest
wr_data  output  DATA_W  to register file data_in
wr_enable  output  1  to register file write_enable
chk_one  input  ADDR_W  decode source one index
chk_two  input  ADDR_W  decode source two index
busy_one  output  1  chk_one has a pending or in-flight write
busy_two  output  1  chk_two has a pending or in-flight write
count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate):
  - FIFO pointers cleared; count=0.
  - wr_enable=0, wr_dest=0, wr_data=0.
  - in_ready=1 once rst deasserts. Entries are discarded.
- Push:
  - in_ready = (count != DEPTH), combinational.
  - Push occurs on an edge with in_valid && in_ready; the entry is written at the tail.
  - Full → in_ready=0 even if a pop happens the same cycle. There is no bypass.
- Pop:
  - On each edge where count>0 and wr_hold=0, the head is popped and registered into wr_dest/wr_data.
  - wr_enable = 1 if head dest != 0, else 0. Writes to x0 are consumed silently.
  - Otherwise wr_enable is 0 next cycle, and wr_dest/wr_data hold their last values.
- wr_enable is high for exactly one cycle per popped non-x0 entry. The register file commits it on the following edge.
- Latency: entry pushed at edge N is presented on wr_* after edge N+1 at the earliest (queue empty, no hold). FIFO order is strict.
- Simultaneous push and pop: count unchanged; both take effect.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Busy (combinational):
  - busy_one = (chk_one != 0) && (match against any occupied entry's dest || (wr_enable && wr_dest == chk_one)).
  - busy_two is the same for chk_two.
  - A same-cycle incoming push does not contribute.
- wr_hold asserted mid-stream: draining stops next edge, wr_enable drops, entries are retained. Draining resumes in order when wr_hold falls.
- Reset during a pending write: wr_enable falls immediately; that write is lost.

Test Plan:
1. Reset, then push (dest=5, data=0xDEADBEEF) with hold=0 → after the next edge, wr_enable=1, wr_dest=5, wr_data=0xDEADBEEF for one cycle; count back to 0.
2. wr_hold=1, push dest 1,2,3,4 (DEPTH=4) → count=4, in_ready=0, a fifth push is not accepted. Release hold → four consecutive wr_enable cycles, order 1,2,3,4, then in_ready=1.
3. Push dest=0 data=0x1234 → popped with wr_enable=0; count decrements; busy for chk=0 never asserts.
4. Hold=1, push dest=7, chk_one=7, chk_two=8 → busy_one=1, busy_two=0. Release: busy_one stays 1 through the wr_enable cycle, then 0.
5. Continuous push every cycle with hold=0, 10 entries → count never exceeds 1, all 10 written in order, one per cycle.
6. Hold=1, push 3 entries, assert rst mid-cycle → count=0 and wr_enable=0 immediately; after release, no writes emerge.
